// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// ALU operand selection and load-use hazard detection.
module id_ex_operand_stage #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_op,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_wsel,
    input  logic [WORD_W-1:0] id_rdat1,
    input  logic [WORD_W-1:0] id_rdat2,
    input  logic [15:0]       id_imm16,
    input  logic [4:0]        id_shamt,
    input  logic [1:0]        id_ext_op,
    input  logic              id_asrc,
    input  logic              id_bsrc,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              stall,
    input  logic              flush,
    input  logic              exmem_regwrite,
    input  logic [REG_W-1:0]  exmem_wsel,
    input  logic [WORD_W-1:0] exmem_result,
    input  logic              memwb_regwrite,
    input  logic [REG_W-1:0]  memwb_wsel,
    input  logic [WORD_W-1:0] memwb_wdat,
    output logic              ex_valid,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [3:0]        ex_alu_op,
    output logic [REG_W-1:0]  ex_wsel,
    output logic [WORD_W-1:0] port_a,
    output logic [WORD_W-1:0] port_b,
    output logic [WORD_W-1:0] ex_store_data,
    output logic              load_use_hazard
);

    typedef enum logic [3:0] {
        ALU_SLL = 4'd0,
        ALU_SRL = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd3
    } aluop_t;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_LUI  = 2'b10,
        EXT_RSVD = 2'b11
    } ext_t;

    logic [REG_W-1:0]  rs_q, rt_q;
    logic [WORD_W-1:0] rdat1_q, rdat2_q, imm_q;
    logic [4:0]        shamt_q;
    logic              asrc_q, bsrc_q;
    logic [WORD_W-1:0] imm_ext, fa, fb;

    always_comb begin
        imm_ext = WORD_W'(id_imm16);
        case (ext_t'(id_ext_op))
            EXT_SIGN: imm_ext = WORD_W'($signed(id_imm16));
            EXT_LUI:  imm_ext = WORD_W'({id_imm16, 16'h0000});
            default:  imm_ext = WORD_W'(id_imm16);
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || flush || (!stall && !id_valid)) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_alu_op   <= ALU_SLL;
            ex_wsel     <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rdat1_q     <= '0;
            rdat2_q     <= '0;
            imm_q       <= '0;
            shamt_q     <= '0;
            asrc_q      <= 1'b0;
            bsrc_q      <= 1'b0;
        end else if (stall) begin
            // Capture forwarded values so a producer retiring mid-stall is not lost.
            rdat1_q <= fa;
            rdat2_q <= fb;
        end else begin
            ex_valid    <= 1'b1;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_alu_op   <= id_alu_op;
            ex_wsel     <= id_wsel;
            rs_q        <= id_rs;
            rt_q        <= id_rt;
            rdat1_q     <= id_rdat1;
            rdat2_q     <= id_rdat2;
            imm_q       <= imm_ext;
            shamt_q     <= id_shamt;
            asrc_q      <= id_asrc;
            bsrc_q      <= id_bsrc;
        end
    end

    always_comb begin
        fa = rdat1_q;
        if (exmem_regwrite && exmem_wsel == rs_q && rs_q != '0)
            fa = exmem_result;
        else if (memwb_regwrite && memwb_wsel == rs_q && rs_q != '0)
            fa = memwb_wdat;

        fb = rdat2_q;
        if (exmem_regwrite && exmem_wsel == rt_q && rt_q != '0)
            fb = exmem_result;
        else if (memwb_regwrite && memwb_wsel == rt_q && rt_q != '0)
            fb = memwb_wdat;
    end

    assign port_a        = asrc_q ? WORD_W'(shamt_q) : fa;
    assign port_b        = bsrc_q ? imm_q : fb;
    assign ex_store_data = fb;

    assign load_use_hazard = ex_valid & ex_memread & (ex_wsel != '0) & id_valid &
                             ((id_rs == ex_wsel) | ((id_rt == ex_wsel) & ~id_bsrc));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: vector table for single-cycle loads,
// hand sequences for stall refresh and load-use/flush behaviour.
module tb_id_ex_operand_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        id_valid;
    logic [3:0]  id_alu_op;
    logic [4:0]  id_rs, id_rt, id_wsel;
    logic [31:0] id_rdat1, id_rdat2;
    logic [15:0] id_imm16;
    logic [4:0]  id_shamt;
    logic [1:0]  id_ext_op;
    logic        id_asrc, id_bsrc, id_regwrite, id_memread;
    logic        stall, flush;
    logic        exmem_regwrite;
    logic [4:0]  exmem_wsel;
    logic [31:0] exmem_result;
    logic        memwb_regwrite;
    logic [4:0]  memwb_wsel;
    logic [31:0] memwb_wdat;
    logic        ex_valid, ex_regwrite, ex_memread;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_wsel;
    logic [31:0] port_a, port_b, ex_store_data;
    logic        load_use_hazard;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [3:0] OP_SLL = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd2;

    id_ex_operand_stage #(.WORD_W(32), .REG_W(5)) dut (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel),
        .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm16(id_imm16),
        .id_shamt(id_shamt), .id_ext_op(id_ext_op), .id_asrc(id_asrc),
        .id_bsrc(id_bsrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .stall(stall), .flush(flush),
        .exmem_regwrite(exmem_regwrite), .exmem_wsel(exmem_wsel), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_alu_op(ex_alu_op), .ex_wsel(ex_wsel), .port_a(port_a), .port_b(port_b),
        .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [4:0]  rs, rt, wsel;
        logic [31:0] rd1, rd2;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic [1:0]  ext;
        logic        asrc, bsrc, rw, mr;
        logic        xw;
        logic [4:0]  xsel;
        logic [31:0] xres;
        logic        mw;
        logic [4:0]  msel;
        logic [31:0] mdat;
        logic [31:0] ea, eb, es;
        logic [3:0]  eop;
        logic [4:0]  ewsel;
        logic        ev, erw, emr;
        string       name;
    } vec_t;

    function automatic vec_t dflt();
        vec_t v;
        v.valid = 1'b1; v.op = OP_ADD; v.rs = '0; v.rt = '0; v.wsel = '0;
        v.rd1 = '0; v.rd2 = '0; v.imm = '0; v.shamt = '0; v.ext = '0;
        v.asrc = 1'b0; v.bsrc = 1'b0; v.rw = 1'b0; v.mr = 1'b0;
        v.xw = 1'b0; v.xsel = '0; v.xres = '0; v.mw = 1'b0; v.msel = '0; v.mdat = '0;
        v.ea = '0; v.eb = '0; v.es = '0; v.eop = OP_ADD; v.ewsel = '0;
        v.ev = 1'b1; v.erw = 1'b0; v.emr = 1'b0; v.name = "";
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        RST = 1'b0; stall = 1'b0; flush = 1'b0;
        id_valid = v.valid; id_alu_op = v.op; id_rs = v.rs; id_rt = v.rt; id_wsel = v.wsel;
        id_rdat1 = v.rd1; id_rdat2 = v.rd2; id_imm16 = v.imm; id_shamt = v.shamt;
        id_ext_op = v.ext; id_asrc = v.asrc; id_bsrc = v.bsrc;
        id_regwrite = v.rw; id_memread = v.mr;
        exmem_regwrite = v.xw; exmem_wsel = v.xsel; exmem_result = v.xres;
        memwb_regwrite = v.mw; memwb_wsel = v.msel; memwb_wdat = v.mdat;
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        // Reset with random ID/forward inputs
        RST = 1'b1; stall = 1'(($urandom)); flush = 1'(($urandom));
        id_valid = 1'b1; id_alu_op = 4'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
        id_wsel = 5'($urandom); id_rdat1 = $urandom; id_rdat2 = $urandom; id_imm16 = 16'($urandom);
        id_shamt = 5'($urandom); id_ext_op = 2'($urandom); id_asrc = 1'($urandom);
        id_bsrc = 1'($urandom); id_regwrite = 1'b1; id_memread = 1'b1;
        exmem_regwrite = 1'b1; exmem_wsel = 5'($urandom); exmem_result = $urandom;
        memwb_regwrite = 1'b1; memwb_wsel = 5'($urandom); memwb_wdat = $urandom;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_port_a", port_a, 32'd0);
        check("rst_port_b", port_b, 32'd0);
        check("rst_store", ex_store_data, 32'd0);
        check("rst_alu_op", 32'(ex_alu_op), 32'(OP_SLL));
        check("rst_wsel", 32'(ex_wsel), 32'd0);
        check("rst_ctrl", 32'({ex_regwrite, ex_memread}), 32'd0);
        check("rst_hazard", 32'(load_use_hazard), 32'd0);

        v = dflt(); v.name = "add_plain"; v.rs = 3; v.rt = 4; v.rd1 = 32'h10; v.rd2 = 32'h20;
        v.wsel = 9; v.rw = 1; v.ea = 32'h10; v.eb = 32'h20; v.es = 32'h20; v.ewsel = 9; v.erw = 1;
        vecs.push_back(v);
        v = dflt(); v.name = "fwd_exmem_prio"; v.rs = 5; v.rt = 4; v.rd1 = 32'h11; v.rd2 = 32'h22;
        v.xw = 1; v.xsel = 5; v.xres = 32'hAAAA0000; v.mw = 1; v.msel = 5; v.mdat = 32'h1234;
        v.ea = 32'hAAAA0000; v.eb = 32'h22; v.es = 32'h22;
        vecs.push_back(v);
        v = dflt(); v.name = "fwd_r0_never"; v.rs = 0; v.rt = 0;
        v.xw = 1; v.xsel = 0; v.xres = 32'hAAAA0000; v.mw = 1; v.msel = 0; v.mdat = 32'h1234;
        v.ea = 32'h0; v.eb = 32'h0; v.es = 32'h0;
        vecs.push_back(v);
        v = dflt(); v.name = "fwd_memwb_rt"; v.rs = 2; v.rt = 6; v.rd1 = 32'h3; v.rd2 = 32'h1;
        v.xw = 1; v.xsel = 7; v.xres = 32'hDEAD; v.mw = 1; v.msel = 6; v.mdat = 32'h55;
        v.ea = 32'h3; v.eb = 32'h55; v.es = 32'h55;
        vecs.push_back(v);
        v = dflt(); v.name = "fwd_exmem_nowr"; v.rs = 9; v.rt = 1; v.rd1 = 32'h4; v.rd2 = 32'h5;
        v.xw = 0; v.xsel = 9; v.xres = 32'hBAD0; v.mw = 1; v.msel = 9; v.mdat = 32'h77;
        v.ea = 32'h77; v.eb = 32'h5; v.es = 32'h5;
        vecs.push_back(v);
        v = dflt(); v.name = "imm_sign"; v.rt = 4; v.rd1 = 32'h8; v.rd2 = 32'h20; v.bsrc = 1;
        v.imm = 16'h8001; v.ext = 2'b01; v.ea = 32'h8; v.eb = 32'hFFFF8001; v.es = 32'h20;
        vecs.push_back(v);
        v = dflt(); v.name = "imm_zero"; v.bsrc = 1; v.imm = 16'h8001; v.ext = 2'b00;
        v.eb = 32'h00008001;
        vecs.push_back(v);
        v = dflt(); v.name = "imm_lui"; v.bsrc = 1; v.imm = 16'h8001; v.ext = 2'b10;
        v.eb = 32'h80010000;
        vecs.push_back(v);
        v = dflt(); v.name = "imm_rsvd"; v.bsrc = 1; v.imm = 16'h8001; v.ext = 2'b11;
        v.eb = 32'h00008001;
        vecs.push_back(v);
        v = dflt(); v.name = "shamt"; v.op = OP_SLL; v.eop = OP_SLL; v.asrc = 1; v.shamt = 7;
        v.rs = 3; v.rd1 = 32'hFFFF; v.rt = 4; v.rd2 = 32'h30; v.wsel = 12; v.mr = 1;
        v.ea = 32'h7; v.eb = 32'h30; v.es = 32'h30; v.ewsel = 12; v.emr = 1;
        vecs.push_back(v);
        v = dflt(); v.name = "invalid_bubble"; v.valid = 0; v.op = 4'hA; v.rs = 3; v.rt = 4;
        v.wsel = 5; v.rd1 = 32'h123; v.rd2 = 32'h456; v.rw = 1; v.mr = 1; v.asrc = 1; v.shamt = 9;
        v.ev = 0; v.eop = OP_SLL;
        vecs.push_back(v);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge CLK);
            #1;
            check({vecs[i].name, "_a"}, port_a, vecs[i].ea);
            check({vecs[i].name, "_b"}, port_b, vecs[i].eb);
            check({vecs[i].name, "_st"}, ex_store_data, vecs[i].es);
            check({vecs[i].name, "_op"}, 32'(ex_alu_op), 32'(vecs[i].eop));
            check({vecs[i].name, "_wsel"}, 32'(ex_wsel), 32'(vecs[i].ewsel));
            check({vecs[i].name, "_ctl"}, 32'({ex_valid, ex_regwrite, ex_memread}),
                  32'({vecs[i].ev, vecs[i].erw, vecs[i].emr}));
        end

        // Stall refresh: MEM/WB forward retires after the first stall cycle
        v = dflt(); v.rs = 3; v.rd1 = 32'h10; v.rt = 6; v.rd2 = 32'h1; v.wsel = 11;
        v.mw = 1; v.msel = 6; v.mdat = 32'h55;
        drive(v);
        @(posedge CLK);
        #1;
        check("stall_pre_b", port_b, 32'h55);
        stall = 1'b1; id_alu_op = 4'hF; id_wsel = 20; id_rt = 1; id_rdat2 = 32'hBEEF;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK);
            #1;
            check("stall_b", port_b, 32'h55);
            check("stall_store", ex_store_data, 32'h55);
            check("stall_a", port_a, 32'h10);
            check("stall_op_hold", 32'(ex_alu_op), 32'(OP_ADD));
            check("stall_wsel_hold", 32'(ex_wsel), 32'd11);
            if (c == 0) begin
                memwb_wsel = 10; memwb_wdat = 32'h99;
            end
        end
        stall = 1'b0;
        #1;
        check("release_b", port_b, 32'h55);

        // Load-use detection, then simultaneous stall+flush
        v = dflt(); v.rs = 1; v.rt = 2; v.wsel = 8; v.rw = 1; v.mr = 1; v.rd1 = 32'h44;
        drive(v);
        @(posedge CLK);
        #1;
        id_valid = 1; id_rs = 8; id_rt = 2; id_bsrc = 0;
        #1 check("lu_rs", 32'(load_use_hazard), 32'd1);
        id_rs = 2; id_rt = 8; id_bsrc = 1;
        #1 check("lu_rt_imm", 32'(load_use_hazard), 32'd0);
        id_bsrc = 0;
        #1 check("lu_rt", 32'(load_use_hazard), 32'd1);
        id_valid = 0;
        #1 check("lu_id_invalid", 32'(load_use_hazard), 32'd0);
        id_valid = 1; id_rs = 8;
        stall = 1'b1; flush = 1'b1;
        @(posedge CLK);
        #1;
        check("flush_valid", 32'(ex_valid), 32'd0);
        check("flush_hazard", 32'(load_use_hazard), 32'd0);
        check("flush_ctl", 32'({ex_regwrite, ex_memread}), 32'd0);
        check("flush_port_a", port_a, 32'd0);
        check("flush_wsel", 32'(ex_wsel), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
